mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter CNT_W, default 32: width of performance counters.
REQ-002 Parameter MEM_TIMEOUT, default 15: max wait cycles for mem_ready before abort.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  11  instruction bits [31:21], valid from the cycle after ir_write.
REQ-006 zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  in  1  memory completion strobe, one cycle per access.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables.
REQ-009 alu_src_a  out  1 (0=PC, 1=Rn); alu_src_b  out  2 (00=Rm, 01=const 4, 10=imm, 11=imm<<2).
REQ-010 alu_op  out  2  ALU op class (00 D-type add, 01 CB pass-B, 10 R-type decode).
REQ-011 mem_to_reg  out  1; pc_src  out  1 (0=ALU result, 1=branch target); iord  out  1 (1=data address).
REQ-012 busy  out  1  high in every state except IDLE; err  out  1  sticky fault flag.
REQ-013 instr_count, cycle_count  out  CNT_W  performance counters.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, FAULT; encoding defined in the package.
REQ-015 IDLE->FETCH unconditionally on the first cycle after reset deasserts.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; on mem_ready, assert ir_write and pc_write for that one cycle, go to DECODE.
REQ-017 DECODE: classify opcode; R-type ADD/SUB/AND/ORR and ADDI (bits[10:1]=1001000100) -> EXEC; LDUR (11111000010) and STUR (11111000000) -> EXEC; CBZ (bits[10:3]=10110100) -> BRANCH; B (bits[10:5]=000101) -> BRANCH; any other -> FAULT.
REQ-018 EXEC: R-type alu_src_b=00, alu_op=10; ADDI/LDUR/STUR alu_src_b=10, alu_op=00 (ADDI uses alu_op=10 with alu_src_b=10). R-type/ADDI -> WB; LDUR/STUR -> MEM.
REQ-019 MEM: iord=1; LDUR mem_read=1, STUR mem_write=1; hold until mem_ready. On mem_ready, LDUR -> WB, STUR -> FETCH.
REQ-020 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LDUR else 0; -> FETCH.
REQ-021 BRANCH: alu_op=01, alu_src_b=11; B: pc_src=1, pc_write=1; CBZ: pc_src=1, pc_write=zero; -> FETCH.
REQ-022 Wait counter counts cycles in FETCH/MEM without mem_ready; on reaching MEM_TIMEOUT -> FAULT with no enable asserted that cycle.
REQ-023 FAULT: err=1, all enables 0, busy=1; remains until reset.
REQ-024 All outputs not named for a state are 0 in that state; outputs are Moore except pc_write/ir_write/reg_write gating by mem_ready/zero.
REQ-025 mem_ready outside FETCH/MEM is ignored.
REQ-026 instr_count increments on every transition into FETCH from WB, MEM(STUR) or BRANCH; cycle_count increments every cycle busy=1; both wrap modulo 2^CNT_W.

Reset
REQ-027 reset asserted at any time, including mid-access, forces state IDLE, all enables 0, err=0, counters 0, wait counter 0 immediately (asynchronously).
REQ-028 No memory write or register write is issued on the cycle reset deasserts.

Configuration
REQ-029 Macro MC_CONTROL_PERF_EN: defined -> counters per REQ-026; undefined -> counter registers not built, instr_count and cycle_count tied 0, ports retained.

Structure
REQ-030 Package mc_pkg holds state encoding, opcode constants (ADD, SUB, AND, ORR, ADDI, LDUR, STUR, CBZ, B), alu_op and alu_src_b codes.
REQ-031 Sub-module mc_decode: combinational opcode -> instruction class (RTYPE, ITYPE, LOAD, STORE, CBZ, B, ILLEGAL).

Verification
REQ-032 ADD 10001011000, mem_ready on 1st FETCH cycle -> FETCH,DECODE,EXEC(alu_op=10),WB(reg_write=1),FETCH; instr_count=1.
REQ-033 LDUR with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1.
REQ-034 CBZ with zero=0 -> pc_write=0 in BRANCH; zero=1 -> pc_write=1, pc_src=1.
REQ-035 opcode 11'b00000000000 -> FAULT, err=1, no further enables until reset.
REQ-036 mem_ready withheld 15 cycles in MEM for STUR -> FAULT, mem_write never coincident with the fault cycle.
REQ-037 reset asserted mid-MEM -> state IDLE, all outputs 0 same cycle; then normal FETCH resumes.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle LEGv8-style controller.
//   state_t     - controller state encoding
//   instr_cls_t - instruction classes produced by mc_decode
//   OP_*        - opcode constants (full 11-bit or prefix fields)
//   ALU_OP_*, SRCB_* - alu_op and alu_src_b codes
//   ctrl_t / ctrl_for - Moore control word for a given state and class
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ITYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_cls_t;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Prefix opcodes: ADDI = opcode[10:1], CBZ = opcode[10:3], B = opcode[10:5]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_RM      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       pc_src;
    logic       busy;
    logic       err;
  } ctrl_t;

  // Moore control word; the mem_ready/zero-gated enables are produced separately.
  function automatic ctrl_t ctrl_for(input state_t st, input instr_cls_t cls);
    ctrl_t c;
    c      = '0;
    c.busy = (st != S_IDLE);
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_OP_ADD;
      end
      S_EXEC: begin
        // First ALU operand is the register Rn for every executed class.
        c.alu_src_a = 1'b1;
        if (cls == CLS_RTYPE) begin
          c.alu_src_b = SRCB_RM;
          c.alu_op    = ALU_OP_RTYPE;
        end else begin
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = (cls == CLS_ITYPE) ? ALU_OP_RTYPE : ALU_OP_ADD;
        end
      end
      S_MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = (cls == CLS_LOAD);
        c.mem_write = (cls == CLS_STORE);
      end
      S_WB: c.mem_to_reg = (cls == CLS_LOAD);
      S_BRANCH: begin
        c.alu_op    = ALU_OP_PASSB;
        c.alu_src_b = SRCB_IMM_SH2;
        c.pc_src    = 1'b1;
      end
      S_FAULT: c.err = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode classifier.
//   opcode [10:0] in  - instruction bits [31:21]
//   cls           out - instruction class (RTYPE/ITYPE/LOAD/STORE/CBZ/B/ILLEGAL)
module mc_decode
  import mc_pkg::*;
(
  input  logic [10:0] opcode,
  output instr_cls_t  cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      cls = CLS_RTYPE;
    else if (opcode[10:1] == OP_ADDI)
      cls = CLS_ITYPE;
    else if (opcode == OP_LDUR)
      cls = CLS_LOAD;
    else if (opcode == OP_STUR)
      cls = CLS_STORE;
    else if (opcode[10:3] == OP_CBZ)
      cls = CLS_CBZ;
    else if (opcode[10:5] == OP_B)
      cls = CLS_B;
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle processor control FSM with memory timeout and
// optional performance counters.
//   clk, reset (async, active-high)
//   opcode[10:0], zero, mem_ready                      - inputs
//   pc_write, ir_write, mem_read, mem_write, reg_write - datapath enables
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], mem_to_reg, pc_src, iord - mux/op selects
//   busy (not IDLE), err (sticky fault)
//   instr_count, cycle_count [CNT_W-1:0] - performance counters
// Build option: define MC_CONTROL_PERF_EN to build the counters; otherwise
// both counter outputs are tied to zero.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic             iord,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  instr_cls_t        cls_q, cls_d, dec_cls;
  ctrl_t             ctrl_q, ctrl_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_phase;
  logic              timeout;

  mc_decode u_decode (
    .opcode (opcode),
    .cls    (dec_cls)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = '0;
    mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    // Timeout fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    timeout   = mem_phase && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    if (mem_phase && !mem_ready)
      wait_d = wait_q + 1'b1;

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE: state_d = S_EXEC;
          CLS_CBZ, CLS_B:                            state_d = S_BRANCH;
          default:                                   state_d = S_FAULT;
        endcase
      end
      S_EXEC:   state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)    state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase

    // Outputs are registered: the control word for the state being entered.
    ctrl_d = ctrl_for(state_d, cls_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_ILLEGAL;
      wait_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Enables that must react within the cycle to mem_ready / zero.
  assign ir_write  = (state_q == S_FETCH) && mem_ready;
  assign pc_write  = ((state_q == S_FETCH) && mem_ready) ||
                     ((state_q == S_BRANCH) && (cls_q == CLS_B || zero));
  assign reg_write = (state_q == S_WB);

  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign iord       = ctrl_q.iord;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign pc_src     = ctrl_q.pc_src;
  assign busy       = ctrl_q.busy;
  assign err        = ctrl_q.err;

`ifdef MC_CONTROL_PERF_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q;
    // Only MEM(STUR) can go MEM->FETCH, so no class check is needed here.
    if (state_d == S_FETCH &&
        (state_q == S_WB || state_q == S_MEM || state_q == S_BRANCH))
      instr_count_d = instr_count_q + 1'b1;
    if (ctrl_q.busy)
      cycle_count_d = cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign cycle_count = cycle_count_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// Control outputs (except alu_src_a) are packed into one vector:
// {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_b, alu_op,
//  mem_to_reg, pc_src, iord, busy, err}
module tb_mc_control;

  localparam int CNT_W = 32;
`ifdef MC_CONTROL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             mem_to_reg, pc_src, iord, busy, err;
  logic [CNT_W-1:0] instr_count, cycle_count;

  int checks = 0;
  int errors = 0;

  mc_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .mem_to_reg  (mem_to_reg),
    .pc_src      (pc_src),
    .iord        (iord),
    .busy        (busy),
    .err         (err),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_b, alu_op,
                mem_to_reg, pc_src, iord, busy, err};

  //                           pcw   irw   mr    mw    rw    srcb   aop    m2r   psrc  iord  busy  err
  localparam logic [13:0] V_ZERO   = '0;
  localparam logic [13:0] V_FWAIT  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_FRDY   = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_EXEC_R = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_EXEC_M = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_MEM_LD = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [13:0] V_MEM_ST = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [13:0] V_WB_R   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_WB_LD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_BR_NT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_BR_T   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] V_FAULT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110101;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_cnt(input string tag, input int n_instr, input int n_cycle);
    chk({tag, "_instr"}, 64'(instr_count), PERF ? 64'(n_instr) : 64'd0);
    chk({tag, "_cycle"}, 64'(cycle_count), PERF ? 64'(n_cycle) : 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered in FETCH (mem_ready low); leaves the DUT in the state after DECODE.
  task automatic do_fetch(input string tag, input logic [10:0] op);
    chk({tag, "_fetch_wait"}, 64'(obs), 64'(V_FWAIT));
    mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch_rdy"}, 64'(obs), 64'(V_FRDY));
    tick();
    mem_ready = 1'b0;
    opcode    = op;
    #1;
    chk({tag, "_decode"}, 64'(obs), 64'(V_DEC));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("reset_outs", 64'(obs), 64'(V_ZERO));
    chk_cnt("reset", 0, 0);
    tick();
    chk("reset_held", 64'(obs), 64'(V_ZERO));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_outs", 64'(obs), 64'(V_ZERO));
    tick();

    // ADD with immediate mem_ready
    chk("fetch_alu_src_a", 64'(alu_src_a), 64'd0);
    do_fetch("add", OP_ADD);
    chk("add_exec", 64'(obs), 64'(V_EXEC_R));
    tick();
    chk("add_wb", 64'(obs), 64'(V_WB_R));
    tick();
    chk_cnt("add", 1, 4);

    // LDUR with mem_ready delayed 3 cycles in MEM
    do_fetch("ldur", OP_LDUR);
    chk("ldur_exec", 64'(obs), 64'(V_EXEC_M));
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("ldur_mem", 64'(obs), 64'(V_MEM_LD));
      tick();
    end
    mem_ready = 1'b0;
    #1;
    chk("ldur_wb", 64'(obs), 64'(V_WB_LD));
    tick();
    chk_cnt("ldur", 2, 12);

    // CBZ not taken, CBZ taken, B unconditional
    do_fetch("cbz0", OP_CBZ);
    zero = 1'b0;
    #1;
    chk("cbz0_branch", 64'(obs), 64'(V_BR_NT));
    tick();
    do_fetch("cbz1", OP_CBZ);
    zero = 1'b1;
    #1;
    chk("cbz1_branch", 64'(obs), 64'(V_BR_T));
    tick();
    zero = 1'b0;
    do_fetch("b", OP_B);
    #1;
    chk("b_branch", 64'(obs), 64'(V_BR_T));
    tick();
    chk_cnt("branch", 5, 21);

    // STUR with immediate completion
    do_fetch("stur", OP_STUR);
    chk("stur_exec", 64'(obs), 64'(V_EXEC_M));
    tick();
    mem_ready = 1'b1;
    #1;
    chk("stur_mem", 64'(obs), 64'(V_MEM_ST));
    tick();
    mem_ready = 1'b0;
    #1;
    chk("stur_back_fetch", 64'(obs), 64'(V_FWAIT));
    chk_cnt("stur", 6, 25);

    // STUR with mem_ready withheld: 15 MEM cycles then FAULT
    do_fetch("sto", OP_STUR);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("sto_mem", 64'(obs), 64'(V_MEM_ST));
      tick();
    end
    chk("sto_fault", 64'(obs), 64'(V_FAULT));
    chk_cnt("sto", 6, 43);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sto_fault_hold", 64'(obs), 64'(V_FAULT));
    end
    mem_ready = 1'b0;

    // Asynchronous reset clears fault and counters
    reset = 1'b1;
    #1;
    chk("fault_reset", 64'(obs), 64'(V_ZERO));
    chk_cnt("fault_reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Illegal opcode
    do_fetch("bad", OP_BAD);
    chk("bad_fault", 64'(obs), 64'(V_FAULT));
    zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i % 2 == 0);
      #1;
      chk("bad_fault_hold", 64'(obs), 64'(V_FAULT));
      tick();
    end
    mem_ready = 1'b0;
    zero      = 1'b0;

    // Reset in the middle of a MEM access
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    do_fetch("mid", OP_LDUR);
    tick();
    chk("mid_mem", 64'(obs), 64'(V_MEM_LD));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset", 64'(obs), 64'(V_ZERO));
    chk("mid_reset_alu_src_a", 64'(alu_src_a), 64'd0);
    chk_cnt("mid_reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_idle", 64'(obs), 64'(V_ZERO));
    tick();
    chk("resume_fetch", 64'(obs), 64'(V_FWAIT));
    chk_cnt("resume", 0, 0);
    mem_ready = 1'b1;
    #1;
    chk("resume_fetch_rdy", 64'(obs), 64'(V_FRDY));
    mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
